text_pixel_renderer: RTL and testbench
======================================

Name: text_pixel_renderer

Overview:
- Back end of the text path. Consumes the font ROM word addressed by the text data generator and selects the current pixel's bit. Outputs registered 12-bit RGB with hsync/vsync delayed to match.
- Sits between the sync generator / data generator / font ROM and the VGA pins.
- Holds double-buffered foreground and background colour registers. A write goes into a shadow register and becomes active only at the next frame start, so a frame never tears.

Parameters:
- ROM_LAT, 1: clk cycles from pixel_x/pixel_y valid to font_word valid (1..4).
- TEXT_COLS, 3: number of 8-pixel character cells in the text window on text row 0.
- HSYNC_ACTIVE, 0: active level of hsync.
- VSYNC_ACTIVE, 0: active level of vsync.
- BLINK_FRAMES, 30: frames per blink phase (BLINK_EN only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- pixel_x  in  10  current pixel column, same cycle as ROM address
- pixel_y  in  10  current pixel row
- video_on  in  1  visible-area flag from sync generator
- hsync_in  in  1  horizontal sync from sync generator
- vsync_in  in  1  vertical sync from sync generator
- font_word  in  8  ROM row data; bit 7 = leftmost pixel; valid ROM_LAT cycles after pixel_x/pixel_y
- color_wr  in  1  one-cycle strobe, loads shadow colours
- fg_color_in  in  12  foreground {R4,G4,B4}
- bg_color_in  in  12  background {R4,G4,B4}
- color_pending  out  1  shadow written, not yet applied
- rgb  out  12  pixel colour
- hsync_out  out  1  hsync delayed ROM_LAT+1 cycles
- vsync_out  out  1  vsync delayed ROM_LAT+1 cycles

Behaviour:
- Clock and reset: one clock (clk). reset_n asynchronous, active-low.
- Pipeline: ROM_LAT stages carry bit_addr = pixel_x[2:0], text_hit, video_on, hsync_in, vsync_in. Stages advance every clk.
- text_hit = (pixel_y < 16) && (pixel_x < TEXT_COLS*8). Comparisons are 10-bit unsigned.
- Stage ROM_LAT combines the delayed fields with font_word: pix = font_word[7 - bit_addr].
- Output register, loaded every clk:
  - delayed video_on=0 -> rgb=0.
  - else text_hit && pix -> rgb = active FG.
  - else -> rgb = active BG.
- Latency: exactly ROM_LAT+1 clk from inputs to rgb/hsync_out/vsync_out.
- Frame start: the cycle vsync_in changes from inactive to VSYNC_ACTIVE, detected with a registered previous value (reset value = inactive).
- Colour handshake, per cycle:
  - color_wr=1: shadow_fg/bg <= inputs; color_pending <= 1.
  - Frame start with color_pending=1: active <= shadow (the values present before this cycle's write).
    - If color_wr also high that cycle: pending stays 1; the new values apply at the next frame start.
    - Else: pending <= 0.
  - Frame start with pending=0: no change.
  - Back-to-back writes before a frame start: last write wins.
- Reset values:
  - rgb=0, color_pending=0.
  - active FG=12'hFFF, active BG=12'h000; shadows equal active values.
  - All pipeline sync stages = inactive level, so hsync_out/vsync_out reset to inactive.
  - video_on and text_hit stages = 0.
- Reset mid-frame: all of the above reset immediately. The first ROM_LAT+1 cycles after release output inactive sync and rgb=0. A pending write is discarded.
- Row/column wrap (pixel_x back to 0 at line start) needs no special handling; the pipeline is position-agnostic.

Optional Feature:
- Macro: TEXT_PIXEL_BLINK_EN.
- Defined:
  - A frame counter (width clog2(BLINK_FRAMES)) increments at each frame start.
  - At BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase (reset value 1).
  - While blink_phase=0, text pixels render BG.
  - Counter and phase reset to 0 and 1.
- Undefined: no counter, no blink logic; text always visible. Ports are identical in both builds.

Test Plan:
- Reset, ROM_LAT=1: pixel_x=0, pixel_y=0, video_on=1, font_word=8'h80 one cycle later -> rgb=12'hFFF exactly 2 clk after the pixel. pixel_x=1 with same word -> rgb=12'h000.
- Window bound: pixel_x=24, pixel_y=0, font_word=8'hFF -> rgb=BG. pixel_x=23 -> FG. pixel_y=16, pixel_x=0 -> BG. video_on=0 -> rgb=0.
- Colour handshake: color_wr with fg=12'h0F0 mid-frame -> color_pending=1, rgb unchanged. On the vsync active edge, active FG=12'h0F0 and pending=0. Next lit text pixel = 12'h0F0.
- Simultaneous events:
  - First write fg=12'hF00.
  - Second write fg=12'h00F in the same cycle as the frame start -> active FG=12'hF00, pending stays 1.
  - Next frame start -> FG=12'h00F, pending=0.
- Reset mid-operation: assert reset_n=0 during lit text with pending=1 -> rgb=0, syncs inactive, pending=0, FG back to 12'hFFF. First valid output arrives ROM_LAT+1 cycles after release.
- TEXT_PIXEL_BLINK_EN, BLINK_FRAMES=2: lit pixel visible in frames 0-1, BG in frames 2-3, visible in frames 4-5.

Source files
------------

// File: rtl/text_pixel_renderer.sv
// Text back end: picks the font bit for each pixel, double-buffers FG/BG colours; ROM_LAT+1 clk latency, no backpressure.
// Optional text blink enabled by defining TEXT_PIXEL_BLINK_EN.
module text_pixel_renderer #(
  parameter int ROM_LAT      = 1,
  parameter int TEXT_COLS    = 3,
  parameter int HSYNC_ACTIVE = 0,
  parameter int VSYNC_ACTIVE = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [7:0]  font_word,
  input  logic        color_wr,
  input  logic [11:0] fg_color_in,
  input  logic [11:0] bg_color_in,
  output logic        color_pending,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic       HS_ON   = (HSYNC_ACTIVE != 0);
  localparam logic       VS_ON   = (VSYNC_ACTIVE != 0);
  localparam logic [9:0] TEXT_W  = 10'(TEXT_COLS * 8);

  logic [2:0]  r_bit [ROM_LAT];
  logic        r_hit [ROM_LAT];
  logic        r_von [ROM_LAT];
  logic        r_hs  [ROM_LAT];
  logic        r_vs  [ROM_LAT];

  logic        r_vs_prev;
  logic        r_pending;
  logic [11:0] r_fg, r_bg, r_fg_sh, r_bg_sh;
  logic [11:0] r_rgb;
  logic        r_hs_out, r_vs_out;

  logic        w_hit, w_pix, w_frame_start, w_blink_vis, w_show_fg;

  assign w_hit         = (pixel_y < 10'd16) && (pixel_x < TEXT_W);
  assign w_pix         = font_word[3'd7 - r_bit[ROM_LAT-1]];
  assign w_frame_start = (vsync_in == VS_ON) && (r_vs_prev != VS_ON);
  assign w_show_fg     = r_hit[ROM_LAT-1] && w_pix && w_blink_vis;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        r_bit[i] <= '0;
        r_hit[i] <= 1'b0;
        r_von[i] <= 1'b0;
        r_hs[i]  <= ~HS_ON;
        r_vs[i]  <= ~VS_ON;
      end
    end else begin
      r_bit[0] <= pixel_x[2:0];
      r_hit[0] <= w_hit;
      r_von[0] <= video_on;
      r_hs[0]  <= hsync_in;
      r_vs[0]  <= vsync_in;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_bit[i] <= r_bit[i-1];
        r_hit[i] <= r_hit[i-1];
        r_von[i] <= r_von[i-1];
        r_hs[i]  <= r_hs[i-1];
        r_vs[i]  <= r_vs[i-1];
      end
    end
  end

  // Active colours only change on a frame start so a frame never tears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_prev <= ~VS_ON;
      r_pending <= 1'b0;
      r_fg      <= 12'hFFF;
      r_bg      <= 12'h000;
      r_fg_sh   <= 12'hFFF;
      r_bg_sh   <= 12'h000;
    end else begin
      r_vs_prev <= vsync_in;
      if (w_frame_start && r_pending) begin
        r_fg      <= r_fg_sh;
        r_bg      <= r_bg_sh;
        r_pending <= 1'b0;
      end
      if (color_wr) begin
        r_fg_sh   <= fg_color_in;
        r_bg_sh   <= bg_color_in;
        r_pending <= 1'b1;
      end
    end
  end

`ifdef TEXT_PIXEL_BLINK_EN
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [CW-1:0] r_frame_cnt;
  logic          r_blink_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_frame_start) begin
      if (r_frame_cnt == CW'(BLINK_FRAMES - 1)) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt   <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign w_blink_vis = r_blink_phase;
`else
  assign w_blink_vis = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb    <= 12'h000;
      r_hs_out <= ~HS_ON;
      r_vs_out <= ~VS_ON;
    end else begin
      r_hs_out <= r_hs[ROM_LAT-1];
      r_vs_out <= r_vs[ROM_LAT-1];
      if (!r_von[ROM_LAT-1])
        r_rgb <= 12'h000;
      else if (w_show_fg)
        r_rgb <= r_fg;
      else
        r_rgb <= r_bg;
    end
  end

  assign rgb           = r_rgb;
  assign hsync_out     = r_hs_out;
  assign vsync_out     = r_vs_out;
  assign color_pending = r_pending;

endmodule

// File: tb/tb_text_pixel_renderer.sv
// Directed bench for text_pixel_renderer (ROM_LAT=1, TEXT_COLS=3, active-low syncs, BLINK_FRAMES=2).
module tb_text_pixel_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, hsync_in, vsync_in;
  logic [7:0]  font_word;
  logic        color_wr;
  logic [11:0] fg_color_in, bg_color_in;
  logic        color_pending;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  text_pixel_renderer #(
    .ROM_LAT(1), .TEXT_COLS(3), .HSYNC_ACTIVE(0), .VSYNC_ACTIVE(0), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .font_word(font_word),
    .color_wr(color_wr), .fg_color_in(fg_color_in), .bg_color_in(bg_color_in),
    .color_pending(color_pending), .rgb(rgb),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y);
    pixel_x = x;
    pixel_y = y;
  endtask

  initial begin
    reset_n = 1'b0;
    pix(10'd0, 10'd0);
    video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    font_word = 8'h80; color_wr = 1'b0;
    fg_color_in = 12'h000; bg_color_in = 12'h000;
    #12;
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_pending", {11'd0, color_pending}, 12'd0);
    chk("rst_hsync", {11'd0, hsync_out}, 12'd1);
    chk("rst_vsync", {11'd0, vsync_out}, 12'd1);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // latency: video_on rises, rgb follows exactly two edges later
    video_on = 1'b1;
    tick(1);
    chk("lat_1clk", rgb, 12'h000);
    tick(1);
    chk("lat_2clk_fg", rgb, 12'hFFF);
    pix(10'd1, 10'd0);
    tick(2);
    chk("x1_bg", rgb, 12'h000);

    // colour handshake
    pix(10'd0, 10'd0);
    tick(2);
    color_wr = 1'b1; fg_color_in = 12'h0F0; bg_color_in = 12'h123;
    tick(1);
    color_wr = 1'b0;
    chk("hs_pending_set", {11'd0, color_pending}, 12'd1);
    tick(2);
    chk("hs_rgb_unchanged", rgb, 12'hFFF);
    vsync_in = 1'b0;
    tick(1);
    chk("hs_pending_clr", {11'd0, color_pending}, 12'd0);
    chk("vs_delay_1", {11'd0, vsync_out}, 12'd1);
    chk("hs_old_fg_inflight", rgb, 12'hFFF);
    tick(1);
    chk("vs_delay_2", {11'd0, vsync_out}, 12'd0);
    chk("hs_new_fg", rgb, 12'h0F0);
    vsync_in = 1'b1;
    pix(10'd1, 10'd0);
    tick(2);
    chk("hs_new_bg", rgb, 12'h123);

    // text window bounds
    font_word = 8'hFF;
    pix(10'd24, 10'd0);  tick(2); chk("win_x24", rgb, 12'h123);
    pix(10'd23, 10'd0);  tick(2); chk("win_x23", rgb, 12'h0F0);
    pix(10'd0, 10'd16);  tick(2); chk("win_y16", rgb, 12'h123);
    pix(10'd0, 10'd15);  tick(2); chk("win_y15", rgb, 12'h0F0);
    pix(10'd1023, 10'd0); tick(2); chk("win_x1023", rgb, 12'h123);
    pix(10'd0, 10'd0);
    video_on = 1'b0; tick(2); chk("video_off", rgb, 12'h000);
    video_on = 1'b1;
    hsync_in = 1'b0;
    tick(1); chk("hsync_delay_1", {11'd0, hsync_out}, 12'd1);
    tick(1); chk("hsync_delay_2", {11'd0, hsync_out}, 12'd0);
    hsync_in = 1'b1;
    tick(2);

    // write coinciding with frame start
    color_wr = 1'b1; fg_color_in = 12'hF00; bg_color_in = 12'h123;
    tick(1);
    color_wr = 1'b1; fg_color_in = 12'h00F; vsync_in = 1'b0;
    tick(1);
    color_wr = 1'b0;
    chk("sim_pending_kept", {11'd0, color_pending}, 12'd1);
    tick(1);
    chk("sim_first_fg", rgb, 12'hF00);
    vsync_in = 1'b1;
    tick(2);
    chk("sim_hold_fg", rgb, 12'hF00);
    vsync_in = 1'b0;
    tick(1);
    chk("sim_pending_clr", {11'd0, color_pending}, 12'd0);
    tick(1);
    chk("sim_second_fg", rgb, 12'h00F);
    vsync_in = 1'b1;
    tick(2);

    // reset mid-operation with a pending write and hsync active
    color_wr = 1'b1; fg_color_in = 12'h0F0;
    hsync_in = 1'b0;
    tick(1);
    color_wr = 1'b0;
    tick(2);
    chk("mid_pending", {11'd0, color_pending}, 12'd1);
    chk("mid_hsync_act", {11'd0, hsync_out}, 12'd0);
    chk("mid_rgb_lit", rgb, 12'h00F);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rgb", rgb, 12'h000);
    chk("mid_rst_hsync", {11'd0, hsync_out}, 12'd1);
    chk("mid_rst_vsync", {11'd0, vsync_out}, 12'd1);
    chk("mid_rst_pending", {11'd0, color_pending}, 12'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    chk("rel_1_rgb", rgb, 12'h000);
    chk("rel_1_hsync", {11'd0, hsync_out}, 12'd1);
    tick(1);
    chk("rel_2_rgb", rgb, 12'hFFF);
    chk("rel_2_hsync", {11'd0, hsync_out}, 12'd0);
    hsync_in = 1'b1;
    vsync_in = 1'b0;
    tick(2);
    chk("rel_discarded", rgb, 12'hFFF);
    vsync_in = 1'b1;
    tick(1);

`ifdef TEXT_PIXEL_BLINK_EN
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    for (int f = 0; f < 6; f++) begin
      chk($sformatf("blink_f%0d", f), rgb, (f >= 2 && f < 4) ? 12'h000 : 12'hFFF);
      vsync_in = 1'b0;
      tick(1);
      vsync_in = 1'b1;
      tick(2);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
